perf_result_buffer: RTL

PERF_RESULT_BUFFER -- requirements
Module: perf_result_buffer

---
 rtl/perf_result_buffer_pkg.sv | 15 +
 rtl/perf_result_buffer_if.sv | 13 +
 rtl/perf_result_buffer_fifo.sv | 80 ++++++++
 rtl/perf_result_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/perf_result_buffer_pkg.sv
// Shared constants and helpers for the perf result buffer.
// The FIFO that stores samples and the capture logic above it both import this package.
package perf_result_buffer_pkg;

  localparam int CNT_W     = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_TAG_W = 8;
  localparam int DROP_W    = 8;

  // Add one to a drop count, but stop at the all-ones value instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] x);
    return (x == {DROP_W{1'b1}}) ? x : x + DROP_W'(1);
  endfunction

endpackage

// File: rtl/perf_result_buffer_if.sv
// Read-side valid/ready port of the perf result buffer.
// Each beat carries a captured count and its sequence tag.
interface perf_result_buffer_if #(
  parameter int TAG_W = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic [TAG_W-1:0] rd_tag;

  modport master (output rd_valid, output rd_data, output rd_tag, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_tag, output rd_ready);
endinterface

// File: rtl/perf_result_buffer_fifo.sv
// Synchronous FIFO holding {count, tag} samples.
// The head entry is kept in a register, so the read data is a flop output and is zero after reset.
module perf_sample_fifo
  import perf_result_buffer_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int W     = CNT_W + DEF_TAG_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  // When the FIFO is full, a write is accepted only if a read frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      head_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
      // The next head is the entry after the one being read, or the entry being written if the FIFO drains.
      if (do_pop && (level_q > LW'(1)))
        head_d = mem[rd_ptr_q + AW'(1)];
      else if (do_push && (empty || do_pop))
        head_d = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr_q] <= push_data;
  end

  assign head_data = head_q;
  assign level     = level_q;

endmodule

// File: rtl/perf_result_buffer.sv
// Captures the final perf counter value on each stop and tags it with a running sequence number.
// Also tracks dropped samples and the largest value captured.
module perf_result_buffer
  import perf_result_buffer_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int TAG_W = DEF_TAG_W,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_W-1:0]      value,
  input  logic                  clear,
  perf_result_buffer_if.master  rd,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]      max_val
);

  localparam int EW = CNT_W + TAG_W;

  logic              armed_q, armed_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  max_val_q, max_val_d;

  logic          capture, take, drop, rd_pop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] head_data;

  // The armed bit follows the upstream counter, so a stop only produces a sample while a measurement is running.
  assign capture = stop & armed_q;
  assign take    = capture & ~clear;
  assign rd_pop  = rd.rd_valid & rd.rd_ready;
  assign drop    = take & fifo_full & ~rd_pop;

  always_comb begin
    armed_d = armed_q;
    if (start && !armed_q)
      armed_d = 1'b1;
    else if (stop && armed_q)
      armed_d = 1'b0;
  end

  always_comb begin
    tag_d      = tag_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    max_val_d  = max_val_q;
    if (clear) begin
      tag_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      max_val_d  = '0;
    end else if (capture) begin
      tag_d = tag_q + TAG_W'(1);
      if (value > max_val_q) max_val_d = value;
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      max_val_q  <= '0;
    end else begin
      armed_q    <= armed_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      max_val_q  <= max_val_d;
    end
  end

  perf_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .push      (take),
    .push_data ({value, tag_q}),
    .pop       (rd_pop),
    .head_data (head_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd.rd_valid = ~fifo_empty;
  assign rd.rd_data  = head_data[EW-1 -: CNT_W];
  assign rd.rd_tag   = head_data[TAG_W-1:0];
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign max_val     = max_val_q;

endmodule
